// File: rtl/ser_feeder_pkg.sv
// Shared types for the serial word feeder: FSM state encoding and
// downstream shift-direction constants.
package ser_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts down from a reload value captured on load and
// flags the last cycle of each period while running.
module bit_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;

    // The period is captured at load so later changes to the reload input
    // cannot disturb a word already in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            period <= '0;
        end else if (load) begin
            cnt    <= reload;
            period <= reload;
        end else if (run) begin
            cnt <= (cnt == '0) ? period : cnt - 1'b1;
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/ser_word_feeder.sv
// Serializes a parallel word into a downstream shift register, ordering the
// bits so the register ends up holding the original word for either direction.
module ser_word_feeder
    import ser_feeder_pkg::*;
#(
    parameter int N     = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_data,
    input  logic             in_dir,
    input  logic [DIV_W-1:0] in_div,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             ser_dir,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  shreg;
    logic          dir_q;
    logic          d_q;
    logic [CW-1:0] bitcnt;
    logic          tick;
    logic          accept;
    logic          last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (bitcnt == LAST);

    bit_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .run    (state == SHIFT),
        .reload (in_div),
        .tick   (tick)
    );

    // Left-shifting downstream needs MSB first; right-shifting needs LSB first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            dir_q  <= 1'b0;
            d_q    <= 1'b0;
            bitcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state  <= SHIFT;
                        shreg  <= in_data;
                        dir_q  <= in_dir;
                        d_q    <= (in_dir == DIR_RIGHT) ? in_data[0] : in_data[N-1];
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (last) begin
                            state  <= IDLE;
                            d_q    <= 1'b0;
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            if (dir_q == DIR_RIGHT) begin
                                shreg <= shreg >> 1;
                                d_q   <= shreg[1];
                            end else begin
                                shreg <= shreg << 1;
                                d_q   <= shreg[N-2];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign ser_en    = busy && tick;
    assign word_done = ser_en && last;
    assign ser_d     = d_q;
    assign ser_dir   = dir_q;

endmodule

// File: tb/tb_ser_word_feeder.sv
// Scoreboarded bench: the driver queues the expected strobe stream per word,
// the monitor checks every strobe, idle outputs and a model downstream register.
module tb_ser_word_feeder;

    localparam int N     = 4;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     in_data = '0;
    logic             in_dir = 1'b0;
    logic [DIV_W-1:0] in_div = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, ser_d, ser_en, ser_dir, busy, word_done;

    ser_word_feeder #(.N(N), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_dir(in_dir),
        .in_div(in_div), .in_valid(in_valid), .in_ready(in_ready),
        .ser_d(ser_d), .ser_en(ser_en), .ser_dir(ser_dir), .busy(busy),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        bit           d;
        bit           dir;
        bit           done;
        logic [N-1:0] word;
    } ev_t;

    ev_t          q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           strobes = 0;
    int           last_end = -100;
    bit           mon_on = 1'b0;
    logic [N-1:0] ds = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int exp_cyc);
        checks++;
        failures++;
        $display("FAIL %s: expected at cyc %0d, now cyc %0d", name, exp_cyc, cyc);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                chk("ready_vs_busy", in_ready, !busy);
                if (!busy) begin
                    chk("idle_ser_d", ser_d, 0);
                    chk("idle_ser_en", ser_en, 0);
                    chk("idle_word_done", word_done, 0);
                end
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    flag("missing_strobe", q[0].cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && busy)
                    chk("ser_d_hold", ser_d, q[0].d);
                if (ser_en) begin
                    if (q.size() == 0) begin
                        flag("unexpected_strobe", -1);
                    end else begin
                        ev = q.pop_front();
                        chk("strobe_cyc", cyc, ev.cyc);
                        chk("strobe_d", ser_d, ev.d);
                        chk("strobe_dir", ser_dir, ev.dir);
                        chk("word_done", word_done, ev.done);
                        if (ev.dir) ds = {ser_d, ds[N-1:1]};
                        else        ds = {ds[N-2:0], ser_d};
                        if (ev.done) begin
                            chk("downstream_word", ds, ev.word);
                            last_end = cyc;
                        end
                    end
                    strobes++;
                end else if (word_done) begin
                    flag("done_without_strobe", -1);
                end
            end
        end
    end

    // Present a word; when wiggle is set, junk is driven with in_valid high
    // while busy and the accept must land on the first IDLE cycle.
    task automatic send(input logic [N-1:0] data, input bit dir,
                        input logic [DIV_W-1:0] div, input bit wiggle);
        bit got = 1'b0;
        int guard = 0;
        int a;
        ev_t e;
        while (!got) begin
            @(negedge clk);
            if (in_ready) begin
                in_data  = data;
                in_dir   = dir;
                in_div   = div;
                in_valid = 1'b1;
                if (wiggle) chk("accept_first_idle", cyc, last_end + 1);
                a = cyc + 1;
                for (int j = 0; j < N; j++) begin
                    e.cyc  = a + (j + 1) * (int'(div) + 1) - 1;
                    e.d    = dir ? data[j] : data[N-1-j];
                    e.dir  = dir;
                    e.done = (j == N - 1);
                    e.word = data;
                    q.push_back(e);
                end
                got = 1'b1;
            end else begin
                in_valid = wiggle;
                in_data  = N'($urandom);
                in_dir   = 1'($urandom);
                in_div   = DIV_W'($urandom_range(0, 5));
                guard++;
                if (guard > 5000) begin
                    flag("accept_timeout", -1);
                    got = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = N'($urandom);
            in_div   = DIV_W'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ser_en"}, ser_en, 0);
        chk({tag, "_ser_d"}, ser_d, 0);
        chk({tag, "_word_done"}, word_done, 0);
        chk({tag, "_ser_dir"}, ser_dir, 0);
    endtask

    initial begin
        int s0, guard;
        bit w;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        mon_on = 1'b1;
        idle(2);

        send(4'b1011, 1'b0, 8'd0, 1'b0);
        idle(3);
        send(4'b1011, 1'b1, 8'd0, 1'b0);
        idle(2);
        send(4'b0110, 1'b0, 8'd2, 1'b0);
        send(4'b1001, 1'b1, 8'd0, 1'b1);
        send(4'b0011, 1'b0, 8'd5, 1'b1);
        send(4'b1110, 1'b1, 8'd1, 1'b1);
        idle(1);

        // Abort mid-word after the 2nd strobe; reset also beats a pending accept.
        send(4'b1100, 1'b1, 8'd1, 1'b0);
        s0 = strobes;
        guard = 0;
        while (strobes - s0 < 2 && guard < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            guard++;
        end
        if (strobes - s0 < 2) flag("abort_strobe_timeout", -1);
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0101;
        @(negedge clk);
        chk("reset_beats_accept", busy, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_quiet("abort");
        idle(3);

        send(4'b1010, 1'b0, 8'hFF, 1'b0);
        for (int k = 0; k < 25; k++) begin
            w = 1'($urandom);
            if (!w) idle($urandom_range(0, 3));
            send(N'($urandom), 1'($urandom), DIV_W'($urandom_range(0, 3)), w);
        end
        idle(1);

        guard = 0;
        while (q.size() > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) flag("drain_timeout", -1);
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
